procyon_lsu_sq_launch: RTL and testbench
========================================

Name: procyon_lsu_sq_launch

Overview:
- Sits between the store-queue entry array and the LSU pipeline.
- Each cycle, picks the oldest retirable SQ entry, starting at the SQ head and wrapping around. Pulses that entry's retire enable, captures its op/tag/addr/data into a launch register, and presents it to the LSU with a valid/ready handshake.
- Tracks each accepted store through the fixed-latency LSU pipeline. Routes the LSU's update result (retry/replay) back to the exact entry that launched it.

Parameters:
- OPTN_SQ_DEPTH, 8, number of SQ entries; power of 2, at least 2.
- OPTN_DATA_WIDTH, 32, store data width.
- OPTN_ADDR_WIDTH, 32, store address width.
- OPTN_ROB_IDX_WIDTH, 5, ROB tag width.
- OPTN_LSU_PIPE_DEPTH, 3, cycles from LSU accept to LSU update; at least 1.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset; synchronous, active-high (1 = reset)
- i_flush  in  1  pipeline flush
- i_sq_head_idx  in  log2(OPTN_SQ_DEPTH)  index of oldest allocated SQ entry
- i_sq_retirable  in  OPTN_SQ_DEPTH  per-entry retirable bits
- i_sq_op  in  OPTN_SQ_DEPTH*PCYN_OP_WIDTH  per-entry op, flattened
- i_sq_tag  in  OPTN_SQ_DEPTH*OPTN_ROB_IDX_WIDTH  per-entry tag
- i_sq_addr  in  OPTN_SQ_DEPTH*OPTN_ADDR_WIDTH  per-entry address
- i_sq_data  in  OPTN_SQ_DEPTH*OPTN_DATA_WIDTH  per-entry data
- o_sq_retire_en  out  OPTN_SQ_DEPTH  one-hot launch pulse to entries
- o_lsu_valid  out  1  launch register valid
- i_lsu_ready  in  1  LSU accepts launch this cycle
- o_lsu_op / o_lsu_tag / o_lsu_addr / o_lsu_data  out  PCYN_OP_WIDTH / ROB_IDX / ADDR / DATA  launched store
- i_lsu_update_en  in  1  LSU result valid
- i_lsu_update_retry, i_lsu_update_replay, i_lsu_update_mhq_retry, i_lsu_update_mhq_replay  in  1 each  result qualifiers
- o_sq_update_en  out  OPTN_SQ_DEPTH  one-hot update enable to entries
- o_sq_update_retry, o_sq_update_replay, o_sq_update_mhq_retry, o_sq_update_mhq_replay  out  1 each  qualifiers broadcast to all entries
- o_inflight  out  1  any store is held in the launch register or in the track pipe

Behaviour:
- Reset:
  - o_lsu_valid=0 and every track-pipe valid bit cleared.
  - o_sq_retire_en=0, o_sq_update_en=0, o_inflight=0.
  - Data registers are not reset.
- Launch register (lreg) is free when o_lsu_valid=0, or when o_lsu_valid & i_lsu_ready in the same cycle.
- Pick:
  - Select the first set bit of i_sq_retirable, scanning from i_sq_head_idx upward modulo OPTN_SQ_DEPTH.
  - Head at 7 with only entry 1 retirable selects entry 1.
- Launch (cycle T):
  - Condition: lreg free & any retirable & !i_flush.
  - o_sq_retire_en has exactly the picked bit set. This is combinational in cycle T.
  - The picked entry's fields load into lreg; o_lsu_valid=1 in T+1.
  - If the launch condition fails, o_sq_retire_en is all 0.
- Hold: o_lsu_valid & !i_lsu_ready keeps lreg fields and the latched entry index stable. No new launch occurs.
- Track pipe:
  - OPTN_LSU_PIPE_DEPTH stages of {valid, entry idx}.
  - An accepted transfer in cycle A writes stage 0. Stages shift every cycle without stalling.
  - The tail stage is valid in cycle A+OPTN_LSU_PIPE_DEPTH.
- Update:
  - o_sq_update_en[tail.idx] = i_lsu_update_en & tail.valid & !i_flush.
  - Qualifiers pass through combinationally.
  - i_lsu_update_en with an invalid tail is ignored: all zeros out.
- Flush:
  - Clears o_lsu_valid and all track valids next cycle.
  - Suppresses launch and update in the flush cycle. Entries return themselves to the nonspeculative state.
  - A flush while lreg is held drops that store.
- Back-to-back: sustained i_lsu_ready=1 gives one launch per cycle. The entry just launched is no longer retirable, so the next cycle picks a different entry.
- Invariants:
  - o_sq_retire_en and o_sq_update_en are each one-hot or zero.
  - An update reaching the LSU with a valid tail in the same cycle as a launch targets a different entry than the launch.
- o_inflight = o_lsu_valid | OR of all track valids.

Decomposition:
- No new package typedefs. PCYN_OP_WIDTH comes from procyon_constants.svh.
- The circular oldest-first picker is local logic: rotate by head, priority-encode, un-rotate.
- Sub-module procyon_lsu_sq_launch_track holds the {valid, idx} shift pipe. Parameters: depth and index width. Ports: flush-clear and tail output.

Test Plan:
- Reset, head=0, retirable=8'b0000_0100, ready=1 -> o_sq_retire_en=0x04 in T; o_lsu_valid=1 with entry-2 fields in T+1; stage 0 written at T+1; at T+1+3 an update_en with retry=1 gives o_sq_update_en=0x04 and o_sq_update_retry=1.
- head=6, retirable=8'b0100_0010 -> entry 6 picked first; entry 1 picked after entry 6 clears (wrap).
- ready=0 for 4 cycles while valid -> lreg stable, o_sq_retire_en=0 throughout; ready=1 -> transfer, next launch the following cycle.
- Flush while lreg valid and two stores in the track pipe -> next cycle o_lsu_valid=0 and o_inflight=0; an update_en 2 cycles later gives o_sq_update_en=0.
- retirable=0xFF, head=0, ready=1 for 8 cycles, retirable bit cleared on launch -> entries 0..7 launched in order, one per cycle; updates return 0x01..0x80 in order.
- Flush coincident with a valid-tail update_en -> o_sq_update_en=0 and no launch that cycle.

Source files
------------

// File: rtl/procyon_lsu_sq_launch_pkg.sv
// Shared constants for the store-queue launch slice.
// PCYN_OP_WIDTH matches the value in procyon_constants.svh.
package procyon_lsu_sq_launch_pkg;

  localparam int PCYN_OP_WIDTH = 5;

endpackage

// File: rtl/procyon_lsu_sq_launch_track.sv
// Fixed-latency {valid, entry idx} shift pipe following stores through the LSU.
// A clear empties every stage so a flushed store never produces an update.
module procyon_lsu_sq_launch_track
  import procyon_lsu_sq_launch_pkg::*;
#(
  parameter int OPTN_DEPTH     = 3,
  parameter int OPTN_IDX_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      i_clear,
  input  logic                      i_valid,
  input  logic [OPTN_IDX_WIDTH-1:0] i_idx,
  output logic                      o_tail_valid,
  output logic [OPTN_IDX_WIDTH-1:0] o_tail_idx,
  output logic                      o_any_valid
);

  logic [OPTN_DEPTH-1:0]     r_valid;
  logic [OPTN_IDX_WIDTH-1:0] r_idx [OPTN_DEPTH];

  always_ff @(posedge clk) begin
    if (n_rst | i_clear) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_valid;
      for (int i = 1; i < OPTN_DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  // Index stages carry no reset; they are only meaningful alongside a valid bit.
  always_ff @(posedge clk) begin
    r_idx[0] <= i_idx;
    for (int i = 1; i < OPTN_DEPTH; i++) begin
      r_idx[i] <= r_idx[i-1];
    end
  end

  assign o_tail_valid = r_valid[OPTN_DEPTH-1];
  assign o_tail_idx   = r_idx[OPTN_DEPTH-1];
  assign o_any_valid  = |r_valid;

endmodule

// File: rtl/procyon_lsu_sq_launch.sv
// Picks the oldest retirable store-queue entry, launches it to the LSU through a
// valid/ready launch register, and routes the LSU result back to that entry.
module procyon_lsu_sq_launch
  import procyon_lsu_sq_launch_pkg::*;
#(
  parameter int OPTN_SQ_DEPTH       = 8,
  parameter int OPTN_DATA_WIDTH     = 32,
  parameter int OPTN_ADDR_WIDTH     = 32,
  parameter int OPTN_ROB_IDX_WIDTH  = 5,
  parameter int OPTN_LSU_PIPE_DEPTH = 3
) (
  input  logic                                        clk,
  input  logic                                        n_rst,
  input  logic                                        i_flush,
  input  logic [$clog2(OPTN_SQ_DEPTH)-1:0]            i_sq_head_idx,
  input  logic [OPTN_SQ_DEPTH-1:0]                    i_sq_retirable,
  input  logic [OPTN_SQ_DEPTH*PCYN_OP_WIDTH-1:0]      i_sq_op,
  input  logic [OPTN_SQ_DEPTH*OPTN_ROB_IDX_WIDTH-1:0] i_sq_tag,
  input  logic [OPTN_SQ_DEPTH*OPTN_ADDR_WIDTH-1:0]    i_sq_addr,
  input  logic [OPTN_SQ_DEPTH*OPTN_DATA_WIDTH-1:0]    i_sq_data,
  output logic [OPTN_SQ_DEPTH-1:0]                    o_sq_retire_en,
  output logic                                        o_lsu_valid,
  input  logic                                        i_lsu_ready,
  output logic [PCYN_OP_WIDTH-1:0]                    o_lsu_op,
  output logic [OPTN_ROB_IDX_WIDTH-1:0]               o_lsu_tag,
  output logic [OPTN_ADDR_WIDTH-1:0]                  o_lsu_addr,
  output logic [OPTN_DATA_WIDTH-1:0]                  o_lsu_data,
  input  logic                                        i_lsu_update_en,
  input  logic                                        i_lsu_update_retry,
  input  logic                                        i_lsu_update_replay,
  input  logic                                        i_lsu_update_mhq_retry,
  input  logic                                        i_lsu_update_mhq_replay,
  output logic [OPTN_SQ_DEPTH-1:0]                    o_sq_update_en,
  output logic                                        o_sq_update_retry,
  output logic                                        o_sq_update_replay,
  output logic                                        o_sq_update_mhq_retry,
  output logic                                        o_sq_update_mhq_replay,
  output logic                                        o_inflight
);

  localparam int IDX_W = $clog2(OPTN_SQ_DEPTH);

  logic [PCYN_OP_WIDTH-1:0]      w_op_arr   [OPTN_SQ_DEPTH];
  logic [OPTN_ROB_IDX_WIDTH-1:0] w_tag_arr  [OPTN_SQ_DEPTH];
  logic [OPTN_ADDR_WIDTH-1:0]    w_addr_arr [OPTN_SQ_DEPTH];
  logic [OPTN_DATA_WIDTH-1:0]    w_data_arr [OPTN_SQ_DEPTH];

  for (genvar g = 0; g < OPTN_SQ_DEPTH; g++) begin : g_unpack
    assign w_op_arr[g]   = i_sq_op[g*PCYN_OP_WIDTH +: PCYN_OP_WIDTH];
    assign w_tag_arr[g]  = i_sq_tag[g*OPTN_ROB_IDX_WIDTH +: OPTN_ROB_IDX_WIDTH];
    assign w_addr_arr[g] = i_sq_addr[g*OPTN_ADDR_WIDTH +: OPTN_ADDR_WIDTH];
    assign w_data_arr[g] = i_sq_data[g*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH];
  end

  // Rotate so the head sits at bit 0, take the lowest set bit, then add the head back.
  logic [2*OPTN_SQ_DEPTH-1:0] w_retirable_dbl;
  logic [OPTN_SQ_DEPTH-1:0]   w_rotated;
  logic [IDX_W-1:0]           w_offset;
  logic [IDX_W-1:0]           w_pick_idx;
  logic                       w_any;

  assign w_retirable_dbl = {i_sq_retirable, i_sq_retirable};
  assign w_rotated       = w_retirable_dbl[i_sq_head_idx +: OPTN_SQ_DEPTH];
  assign w_any           = |i_sq_retirable;

  always_comb begin
    w_offset = '0;
    for (int k = OPTN_SQ_DEPTH - 1; k >= 0; k--) begin
      if (w_rotated[k]) w_offset = IDX_W'(k);
    end
  end

  assign w_pick_idx = i_sq_head_idx + w_offset;

  logic                          r_lsu_valid;
  logic [IDX_W-1:0]              r_lsu_idx;
  logic [PCYN_OP_WIDTH-1:0]      r_lsu_op;
  logic [OPTN_ROB_IDX_WIDTH-1:0] r_lsu_tag;
  logic [OPTN_ADDR_WIDTH-1:0]    r_lsu_addr;
  logic [OPTN_DATA_WIDTH-1:0]    r_lsu_data;
  logic                          w_lreg_free;
  logic                          w_launch;
  logic                          w_accept;

  assign w_lreg_free    = ~r_lsu_valid | i_lsu_ready;
  assign w_launch       = w_lreg_free & w_any & ~i_flush;
  assign w_accept       = r_lsu_valid & i_lsu_ready;
  assign o_sq_retire_en = w_launch ? (OPTN_SQ_DEPTH'(1) << w_pick_idx) : '0;

  always_ff @(posedge clk) begin
    if (n_rst | i_flush) r_lsu_valid <= 1'b0;
    else if (w_launch)   r_lsu_valid <= 1'b1;
    else if (w_accept)   r_lsu_valid <= 1'b0;
  end

  // Launch payload and its source entry; untouched while the LSU stalls.
  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_lsu_idx  <= w_pick_idx;
      r_lsu_op   <= w_op_arr[w_pick_idx];
      r_lsu_tag  <= w_tag_arr[w_pick_idx];
      r_lsu_addr <= w_addr_arr[w_pick_idx];
      r_lsu_data <= w_data_arr[w_pick_idx];
    end
  end

  assign o_lsu_valid = r_lsu_valid;
  assign o_lsu_op    = r_lsu_op;
  assign o_lsu_tag   = r_lsu_tag;
  assign o_lsu_addr  = r_lsu_addr;
  assign o_lsu_data  = r_lsu_data;

  logic             w_tail_valid;
  logic [IDX_W-1:0] w_tail_idx;
  logic             w_track_any;
  logic             w_update;

  procyon_lsu_sq_launch_track #(
    .OPTN_DEPTH     (OPTN_LSU_PIPE_DEPTH),
    .OPTN_IDX_WIDTH (IDX_W)
  ) u_track (
    .clk          (clk),
    .n_rst        (n_rst),
    .i_clear      (i_flush),
    .i_valid      (w_accept),
    .i_idx        (r_lsu_idx),
    .o_tail_valid (w_tail_valid),
    .o_tail_idx   (w_tail_idx),
    .o_any_valid  (w_track_any)
  );

  assign w_update               = i_lsu_update_en & w_tail_valid & ~i_flush;
  assign o_sq_update_en         = w_update ? (OPTN_SQ_DEPTH'(1) << w_tail_idx) : '0;
  assign o_sq_update_retry      = i_lsu_update_retry;
  assign o_sq_update_replay     = i_lsu_update_replay;
  assign o_sq_update_mhq_retry  = i_lsu_update_mhq_retry;
  assign o_sq_update_mhq_replay = i_lsu_update_mhq_replay;
  assign o_inflight             = r_lsu_valid | w_track_any;

endmodule

// File: tb/tb_procyon_lsu_sq_launch.sv
// Self-checking bench for the store-queue launch block: directed vector table,
// hand-written corner sequences and randomized traffic against a queue-based model.
module tb_procyon_lsu_sq_launch;
  import procyon_lsu_sq_launch_pkg::*;

  localparam int SQ_DEPTH   = 8;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int TAG_W      = 5;
  localparam int PIPE_DEPTH = 3;
  localparam int OP_W       = PCYN_OP_WIDTH;

  logic                       clk;
  logic                       nRst;
  logic                       flush;
  logic [2:0]                 headIdx;
  logic [SQ_DEPTH-1:0]        retirable;
  logic [SQ_DEPTH*OP_W-1:0]   sqOpFlat;
  logic [SQ_DEPTH*TAG_W-1:0]  sqTagFlat;
  logic [SQ_DEPTH*ADDR_W-1:0] sqAddrFlat;
  logic [SQ_DEPTH*DATA_W-1:0] sqDataFlat;
  logic [SQ_DEPTH-1:0]        retireEn;
  logic                       lsuValid;
  logic                       lsuReady;
  logic [OP_W-1:0]            lsuOp;
  logic [TAG_W-1:0]           lsuTag;
  logic [ADDR_W-1:0]          lsuAddr;
  logic [DATA_W-1:0]          lsuData;
  logic                       updEn;
  logic [3:0]                 updQuals;
  logic [SQ_DEPTH-1:0]        sqUpdateEn;
  logic                       sqUpdRetry, sqUpdReplay, sqUpdMhqRetry, sqUpdMhqReplay;
  logic                       inflight;

  logic [OP_W-1:0]   entOp   [SQ_DEPTH];
  logic [TAG_W-1:0]  entTag  [SQ_DEPTH];
  logic [ADDR_W-1:0] entAddr [SQ_DEPTH];
  logic [DATA_W-1:0] entData [SQ_DEPTH];

  always_comb begin
    sqOpFlat   = '0;
    sqTagFlat  = '0;
    sqAddrFlat = '0;
    sqDataFlat = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      sqOpFlat[i*OP_W +: OP_W]       = entOp[i];
      sqTagFlat[i*TAG_W +: TAG_W]    = entTag[i];
      sqAddrFlat[i*ADDR_W +: ADDR_W] = entAddr[i];
      sqDataFlat[i*DATA_W +: DATA_W] = entData[i];
    end
  end

  procyon_lsu_sq_launch #(
    .OPTN_SQ_DEPTH       (SQ_DEPTH),
    .OPTN_DATA_WIDTH     (DATA_W),
    .OPTN_ADDR_WIDTH     (ADDR_W),
    .OPTN_ROB_IDX_WIDTH  (TAG_W),
    .OPTN_LSU_PIPE_DEPTH (PIPE_DEPTH)
  ) dut (
    .clk                     (clk),
    .n_rst                   (nRst),
    .i_flush                 (flush),
    .i_sq_head_idx           (headIdx),
    .i_sq_retirable          (retirable),
    .i_sq_op                 (sqOpFlat),
    .i_sq_tag                (sqTagFlat),
    .i_sq_addr               (sqAddrFlat),
    .i_sq_data               (sqDataFlat),
    .o_sq_retire_en          (retireEn),
    .o_lsu_valid             (lsuValid),
    .i_lsu_ready             (lsuReady),
    .o_lsu_op                (lsuOp),
    .o_lsu_tag               (lsuTag),
    .o_lsu_addr              (lsuAddr),
    .o_lsu_data              (lsuData),
    .i_lsu_update_en         (updEn),
    .i_lsu_update_retry      (updQuals[3]),
    .i_lsu_update_replay     (updQuals[2]),
    .i_lsu_update_mhq_retry  (updQuals[1]),
    .i_lsu_update_mhq_replay (updQuals[0]),
    .o_sq_update_en          (sqUpdateEn),
    .o_sq_update_retry       (sqUpdRetry),
    .o_sq_update_replay      (sqUpdReplay),
    .o_sq_update_mhq_retry   (sqUpdMhqRetry),
    .o_sq_update_mhq_replay  (sqUpdMhqReplay),
    .o_inflight              (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: the launch slot plus a list of stores with the cycle their
  // result is due back from the LSU.
  typedef struct {
    int idx;
    int due;
  } pend_t;

  pend_t             pending[$];
  bit                mValid;
  int                mIdx;
  logic [OP_W-1:0]   mOp;
  logic [TAG_W-1:0]  mTag;
  logic [ADDR_W-1:0] mAddr;
  logic [DATA_W-1:0] mData;
  int                mCycle;
  bit                mLaunch;
  int                mPick;
  bit                autoClear;

  typedef struct {
    bit       flush;
    bit [2:0] head;
    bit [7:0] ret;
    bit       ready;
    bit       updEn;
    bit [3:0] quals;
    bit [7:0] expRet;
    bit       expValid;
    bit [7:0] expUpd;
    bit       expInflight;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, mCycle, actual, expected);
    end
  endtask

  // Inputs are already driven; settle to the falling edge and compare with the model.
  task automatic applyStimulus();
    bit       freeSlot;
    bit       anyRet;
    bit [7:0] expRet;
    bit [7:0] expUpd;
    int       e;
    @(negedge clk);
    while (pending.size() > 0 && pending[0].due < mCycle) void'(pending.pop_front());
    freeSlot = !mValid || lsuReady;
    anyRet   = 1'b0;
    mPick    = 0;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      e = (int'(headIdx) + k) % SQ_DEPTH;
      if (!anyRet && retirable[e]) begin
        anyRet = 1'b1;
        mPick  = e;
      end
    end
    mLaunch = freeSlot && anyRet && !flush;
    expRet  = mLaunch ? 8'(1 << mPick) : 8'h00;
    expUpd  = 8'h00;
    if (updEn && !flush && pending.size() > 0) begin
      if (pending[0].due == mCycle) expUpd = 8'(1 << pending[0].idx);
    end
    checkOutput("retire_en", 64'(retireEn), 64'(expRet));
    checkOutput("lsu_valid", 64'(lsuValid), 64'(mValid));
    if (mValid) begin
      checkOutput("lsu_op",   64'(lsuOp),   64'(mOp));
      checkOutput("lsu_tag",  64'(lsuTag),  64'(mTag));
      checkOutput("lsu_addr", 64'(lsuAddr), 64'(mAddr));
      checkOutput("lsu_data", 64'(lsuData), 64'(mData));
    end
    checkOutput("update_en", 64'(sqUpdateEn), 64'(expUpd));
    checkOutput("update_quals", 64'({sqUpdRetry, sqUpdReplay, sqUpdMhqRetry, sqUpdMhqReplay}), 64'(updQuals));
    checkOutput("inflight", 64'(inflight), 64'(mValid || pending.size() > 0));
  endtask

  task automatic endCycle();
    bit accept;
    accept = mValid && lsuReady;
    if (flush) begin
      mValid = 1'b0;
      pending.delete();
    end else begin
      if (accept) pending.push_back('{idx: mIdx, due: mCycle + PIPE_DEPTH});
      if (mLaunch) begin
        mValid = 1'b1;
        mIdx   = mPick;
        mOp    = entOp[mPick];
        mTag   = entTag[mPick];
        mAddr  = entAddr[mPick];
        mData  = entData[mPick];
      end else if (accept) begin
        mValid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (autoClear && mLaunch) retirable[mPick] = 1'b0;
    mCycle++;
  endtask

  task automatic setIdle();
    flush     = 1'b0;
    retirable = '0;
    lsuReady  = 1'b1;
    updEn     = 1'b0;
    updQuals  = 4'h0;
  endtask

  task automatic idleCycles(input int n);
    setIdle();
    for (int i = 0; i < n; i++) begin
      applyStimulus();
      endCycle();
    end
  endtask

  function automatic void addVec(input bit f, input bit [2:0] h, input bit [7:0] r, input bit rdy,
                                 input bit u, input bit [3:0] q, input bit [7:0] eRet, input bit eV,
                                 input bit [7:0] eUpd, input bit eInf);
    vec_t v;
    v.flush = f; v.head = h; v.ret = r; v.ready = rdy; v.updEn = u; v.quals = q;
    v.expRet = eRet; v.expValid = eV; v.expUpd = eUpd; v.expInflight = eInf;
    vecs.push_back(v);
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < SQ_DEPTH; i++) begin
      entOp[i]   = OP_W'(i + 1);
      entTag[i]  = TAG_W'(i * 3 + 1);
      entAddr[i] = 32'h1000_0000 + 32'(i * 16);
      entData[i] = 32'hA5A5_0000 | 32'(i);
    end
    nRst      = 1'b1;
    headIdx   = 3'd0;
    autoClear = 1'b0;
    setIdle();
    mValid = 1'b0;
    mIdx   = 0;
    mCycle = 0;
    repeat (2) @(posedge clk);
    #1;
    nRst = 1'b0;

    // Directed table: single launch + update, wrap pick, stall, late qualifiers.
    addVec(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0);
    addVec(1'b0, 3'd0, 8'h04, 1'b1, 1'b0, 4'h0, 8'h04, 1'b0, 8'h00, 1'b0);
    addVec(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 1'b1);
    addVec(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1);
    addVec(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1);
    addVec(1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 4'h8, 8'h00, 1'b0, 8'h04, 1'b1);
    addVec(1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0);
    addVec(1'b0, 3'd6, 8'h42, 1'b1, 1'b0, 4'h0, 8'h40, 1'b0, 8'h00, 1'b0);
    addVec(1'b0, 3'd6, 8'h02, 1'b1, 1'b0, 4'h0, 8'h02, 1'b1, 8'h00, 1'b1);
    addVec(1'b0, 3'd6, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 1'b1);
    addVec(1'b0, 3'd6, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1);
    addVec(1'b0, 3'd6, 8'h00, 1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 8'h40, 1'b1);
    addVec(1'b0, 3'd6, 8'h00, 1'b1, 1'b1, 4'h4, 8'h00, 1'b0, 8'h02, 1'b1);
    addVec(1'b0, 3'd7, 8'h02, 1'b1, 1'b0, 4'h0, 8'h02, 1'b0, 8'h00, 1'b0);
    addVec(1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 1'b1);
    addVec(1'b0, 3'd7, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 1'b1);
    addVec(1'b0, 3'd7, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1);
    addVec(1'b0, 3'd7, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1);
    addVec(1'b0, 3'd7, 8'h00, 1'b1, 1'b1, 4'h2, 8'h00, 1'b0, 8'h02, 1'b1);
    addVec(1'b0, 3'd7, 8'h00, 1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0);

    for (int v = 0; v < vecs.size(); v++) begin
      flush     = vecs[v].flush;
      headIdx   = vecs[v].head;
      retirable = vecs[v].ret;
      lsuReady  = vecs[v].ready;
      updEn     = vecs[v].updEn;
      updQuals  = vecs[v].quals;
      applyStimulus();
      checkOutput("vec_retire_en", 64'(retireEn),   64'(vecs[v].expRet));
      checkOutput("vec_lsu_valid", 64'(lsuValid),   64'(vecs[v].expValid));
      checkOutput("vec_update_en", 64'(sqUpdateEn), 64'(vecs[v].expUpd));
      checkOutput("vec_inflight",  64'(inflight),   64'(vecs[v].expInflight));
      endCycle();
    end

    // Stall: entry 4 held for four cycles, then entry 5 launches on the transfer.
    autoClear = 1'b1;
    setIdle();
    headIdx   = 3'd0;
    retirable = 8'h30;
    applyStimulus();
    checkOutput("hold_first_launch", 64'(retireEn), 64'h10);
    endCycle();
    lsuReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("hold_retire_en", 64'(retireEn), 64'h00);
      checkOutput("hold_valid", 64'(lsuValid), 64'h1);
      checkOutput("hold_tag", 64'(lsuTag), 64'(entTag[4]));
      endCycle();
    end
    lsuReady = 1'b1;
    applyStimulus();
    checkOutput("hold_release_launch", 64'(retireEn), 64'h20);
    endCycle();
    applyStimulus();
    checkOutput("hold_next_tag", 64'(lsuTag), 64'(entTag[5]));
    endCycle();
    idleCycles(5);

    // Flush while the launch slot is held and two stores are in the track pipe.
    retirable = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      endCycle();
    end
    lsuReady = 1'b0;
    flush    = 1'b1;
    applyStimulus();
    checkOutput("flush_no_launch", 64'(retireEn), 64'h00);
    endCycle();
    flush     = 1'b0;
    lsuReady  = 1'b1;
    retirable = 8'h00;
    updEn     = 1'b1;
    applyStimulus();
    checkOutput("flush_valid_cleared", 64'(lsuValid), 64'h0);
    checkOutput("flush_inflight_cleared", 64'(inflight), 64'h0);
    endCycle();
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      checkOutput("flush_update_dropped", 64'(sqUpdateEn), 64'h00);
      endCycle();
    end
    idleCycles(2);

    // Flush in the same cycle the tail carries a valid result.
    retirable = 8'h01;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      endCycle();
    end
    flush     = 1'b1;
    updEn     = 1'b1;
    retirable = 8'h80;
    applyStimulus();
    checkOutput("flush_tail_update", 64'(sqUpdateEn), 64'h00);
    checkOutput("flush_tail_launch", 64'(retireEn), 64'h00);
    endCycle();
    idleCycles(2);

    // Back-to-back: every entry retirable, one launch per cycle, updates in order.
    retirable = 8'hFF;
    updEn     = 1'b1;
    for (int j = 0; j < 14; j++) begin
      applyStimulus();
      checkOutput("b2b_retire_en", 64'(retireEn), (j < 8) ? 64'(1 << j) : 64'h0);
      checkOutput("b2b_update_en", 64'(sqUpdateEn), (j >= 4 && j < 12) ? 64'(1 << (j - 4)) : 64'h0);
      endCycle();
    end
    idleCycles(2);

    // Randomized traffic checked only against the model.
    for (int c = 0; c < 400; c++) begin
      flush    = ($urandom_range(0, 15) == 0);
      lsuReady = ($urandom_range(0, 3) != 0);
      updEn    = $urandom_range(0, 1) == 1;
      updQuals = 4'($urandom);
      if ($urandom_range(0, 7) == 0) headIdx = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) retirable = retirable | 8'($urandom);
      begin
        int r;
        r = $urandom_range(0, SQ_DEPTH - 1);
        entOp[r]   = OP_W'($urandom);
        entTag[r]  = TAG_W'($urandom);
        entAddr[r] = $urandom;
        entData[r] = $urandom;
      end
      applyStimulus();
      endCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
